// File: rtl/key_icon_animator.sv
// key_icon_animator: ROM key-icon renderer with integer up-scaling, select blink and press sink animation
// Ports: clk; resetN (sync, active-high); startOfFrame frame pulse; offsetX/offsetY pixel offset in object;
// InsideRectangle pixel-in-object flag; glyphSel glyph index; selected focus level; keyPress activation pulse;
// drawingRequest opaque flag; RGBout pixel colour (2-cycle latency); busy pressed effect active.
module key_icon_animator #(
  parameter int TILE_BITS = 5,
  parameter int SCALE_SHIFT = 0,
  parameter int NUM_GLYPHS = 4,
  parameter int BLINK_FRAMES = 16,
  parameter int PRESS_FRAMES = 8,
  parameter int PRESS_SHIFT = 2,
  parameter logic [7:0] FACE_COLOR = 8'h71,
  parameter logic [7:0] HILITE_COLOR = 8'hFC,
  parameter logic [7:0] TRANSPARENT = 8'h00,
  localparam int GSEL_W = NUM_GLYPHS > 1 ? $clog2(NUM_GLYPHS) : 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              startOfFrame,
  input  logic [10:0]       offsetX,
  input  logic [10:0]       offsetY,
  input  logic              InsideRectangle,
  input  logic [GSEL_W-1:0] glyphSel,
  input  logic              selected,
  input  logic              keyPress,
  output logic              drawingRequest,
  output logic [7:0]        RGBout,
  output logic              busy
);
  localparam int N = 1 << TILE_BITS;
  localparam int MAXF = BLINK_FRAMES > PRESS_FRAMES ? BLINK_FRAMES : PRESS_FRAMES;
  localparam int CW = MAXF > 1 ? $clog2(MAXF) : 1;

  typedef enum logic [1:0] {IDLE, SEL_ON, SEL_OFF, PRESSED} state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [GSEL_W-1:0]      glyph_q, g1_q;
  logic [TILE_BITS-1:0]   x1_q, y1_q;
  logic                   rng1_q, ins1_q, hl1_q;
  logic [7:0]             rgb_q, rgb_d, pix;
  logic [10:0]            tx;
  logic [11:0]            ty;
  logic                   in_rng;

  // Glyph art: 2-pixel transparent border, 2-pixel shadow on bottom/right, face elsewhere.
  // 0 plus, 1 minus, 2 vertical bar, 3+ blank key.
  function automatic logic [7:0] rom(input logic [GSEL_W-1:0] g, input logic [TILE_BITS-1:0] x, input logic [TILE_BITS-1:0] y);
    int xi, yi, gi;
    logic vb, hb;
    xi = int'(x);
    yi = int'(y);
    gi = int'(g);
    vb = xi >= N/2-3 && xi <= N/2+2 && yi >= N/4 && yi < 3*N/4;
    hb = yi >= N/2-3 && yi <= N/2+2 && xi >= N/4 && xi < 3*N/4;
    return (xi < 2 || yi < 2 || xi >= N-2 || yi >= N-2) ? TRANSPARENT :
           (xi >= N-4 || yi >= N-4) ? 8'h6D :
           ((gi == 0 && (vb || hb)) || (gi == 1 && hb) || (gi == 2 && vb)) ? 8'hFF : 8'h71;
  endfunction

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q <= IDLE;
      cnt_q <= '0;
      glyph_q <= '0;
    end else begin
      if (startOfFrame) glyph_q <= glyphSel;
      if (keyPress) begin
        state_q <= PRESSED;
        cnt_q <= '0;
      end else if (startOfFrame) begin
        case (state_q)
          IDLE: if (selected) begin
            state_q <= SEL_ON;
            cnt_q <= '0;
          end
          SEL_ON, SEL_OFF: if (!selected) begin
            state_q <= IDLE;
            cnt_q <= '0;
          end else if (cnt_q == CW'(BLINK_FRAMES-1)) begin
            state_q <= state_q == SEL_ON ? SEL_OFF : SEL_ON;
            cnt_q <= '0;
          end else cnt_q <= cnt_q + 1'b1;
          default: if (cnt_q == CW'(PRESS_FRAMES-1)) begin
            state_q <= selected ? SEL_ON : IDLE;
            cnt_q <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        endcase
      end
    end
  end

  // ty is kept 12 bits wide so the press shift can go negative above the tile.
  always_comb begin
    tx = offsetX >> SCALE_SHIFT;
    ty = {1'b0, offsetY >> SCALE_SHIFT} - (state_q == PRESSED ? 12'(PRESS_SHIFT) : 12'd0);
    in_rng = !ty[11] && tx < 11'(N) && ty < 12'(N) && int'(glyph_q) < NUM_GLYPHS;
    pix = rom(g1_q, x1_q, y1_q);
    rgb_d = (rng1_q && ins1_q) ? ((hl1_q && pix == FACE_COLOR) ? HILITE_COLOR : pix) : TRANSPARENT;
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      rng1_q <= 1'b0;
      ins1_q <= 1'b0;
      hl1_q <= 1'b0;
      g1_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      rgb_q <= TRANSPARENT;
    end else begin
      rng1_q <= in_rng;
      ins1_q <= InsideRectangle;
      hl1_q <= state_q == SEL_ON;
      g1_q <= glyph_q;
      x1_q <= tx[TILE_BITS-1:0];
      y1_q <= ty[TILE_BITS-1:0];
      rgb_q <= rgb_d;
    end
  end

  assign RGBout = rgb_q;
  assign drawingRequest = rgb_q != TRANSPARENT;
  assign busy = state_q == PRESSED;
endmodule

// File: tb/tb_key_icon_animator.sv
// tb_key_icon_animator: scoreboard bench for key_icon_animator (default DUT a, scaled 3-glyph DUT b)
module tb_key_icon_animator;
  logic clk = 1'b0, rst = 1'b1, sof = 1'b0, inr = 1'b0, sel = 1'b0, kp = 1'b0;
  logic [10:0] ox = '0, oy = '0;
  logic [1:0] gs = '0;
  logic dr_a, dr_b, busy_a, busy_b;
  logic [7:0] rgb_a, rgb_b;
  logic probe_v = 1'b0, snap = 1'b0, p1 = 1'b0, p2 = 1'b0;
  int tests = 0, fails = 0;
  string qn[$];
  bit qd[$], qc[$], qb[$];
  logic [7:0] qr[$];
  string n;
  bit d, c, eb;
  logic [7:0] er, ar;
  logic adr, ab;

  always #5 clk = ~clk;

  key_icon_animator dut_a (
    .clk(clk), .resetN(rst), .startOfFrame(sof), .offsetX(ox), .offsetY(oy),
    .InsideRectangle(inr), .glyphSel(gs), .selected(sel), .keyPress(kp),
    .drawingRequest(dr_a), .RGBout(rgb_a), .busy(busy_a)
  );

  key_icon_animator #(.SCALE_SHIFT(1), .NUM_GLYPHS(3)) dut_b (
    .clk(clk), .resetN(rst), .startOfFrame(sof), .offsetX(ox), .offsetY(oy),
    .InsideRectangle(inr), .glyphSel(gs), .selected(sel), .keyPress(kp),
    .drawingRequest(dr_b), .RGBout(rgb_b), .busy(busy_b)
  );

  // Probe flags follow the DUT's two-stage pixel latency.
  always @(posedge clk) begin
    p1 <= probe_v;
    p2 <= p1;
  end

  always @(negedge clk) begin
    if (p2 || snap) begin
      if (qn.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_sample: no expectation queued");
      end else begin
        n = qn.pop_front();
        d = qd.pop_front();
        c = qc.pop_front();
        er = qr.pop_front();
        eb = qb.pop_front();
        ar = d ? rgb_b : rgb_a;
        adr = d ? dr_b : dr_a;
        ab = d ? busy_b : busy_a;
        if (c) begin
          tests++;
          if (ar !== er) begin
            fails++;
            $display("FAIL %s rgb: got %h expected %h", n, ar, er);
          end
          tests++;
          if (adr !== (er != 8'h00)) begin
            fails++;
            $display("FAIL %s drawingRequest: got %b expected %b", n, adr, er != 8'h00);
          end
        end
        tests++;
        if (ab !== eb) begin
          fails++;
          $display("FAIL %s busy: got %b expected %b", n, ab, eb);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int k);
    repeat (k) begin
      sof = 1'b1;
      cyc();
      sof = 1'b0;
      cyc();
    end
  endtask

  task automatic push(input string nm, input bit dd, input bit cc, input logic [7:0] r, input bit b);
    qn.push_back(nm);
    qd.push_back(dd);
    qc.push_back(cc);
    qr.push_back(r);
    qb.push_back(b);
  endtask

  task automatic probe(input string nm, input bit dd, input int x, input int y, input bit ins, input logic [7:0] r, input bit b);
    ox = 11'(x);
    oy = 11'(y);
    inr = ins;
    push(nm, dd, 1'b1, r, b);
    probe_v = 1'b1;
    cyc();
    probe_v = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic check(input string nm, input bit dd, input bit cc, input logic [7:0] r, input bit b);
    push(nm, dd, cc, r, b);
    snap = 1'b1;
    cyc();
    snap = 1'b0;
  endtask

  task automatic press(input bit with_sof);
    kp = 1'b1;
    sof = with_sof;
    cyc();
    kp = 1'b0;
    sof = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc();
    cyc();
    check("reset_a", 1'b0, 1'b1, 8'h00, 1'b0);
    check("reset_b", 1'b1, 1'b1, 8'h00, 1'b0);
    rst = 1'b0;
    cyc();
    probe("plus_cross", 0, 13, 9, 1, 8'hFF, 0);
    probe("corner", 0, 0, 0, 1, 8'h00, 0);
    probe("outside_rect", 0, 13, 9, 0, 8'h00, 0);
    probe("face_idle", 0, 5, 3, 1, 8'h71, 0);
    probe("shadow", 0, 28, 5, 1, 8'h6D, 0);
    probe("off_tile", 0, 40, 5, 1, 8'h00, 0);
    sel = 1'b1;
    pulse(1);
    probe("sel_on_first", 0, 5, 3, 1, 8'hFC, 0);
    pulse(15);
    probe("sel_on_end", 0, 5, 3, 1, 8'hFC, 0);
    pulse(1);
    probe("sel_off_16", 0, 5, 3, 1, 8'h71, 0);
    pulse(15);
    probe("sel_off_end", 0, 5, 3, 1, 8'h71, 0);
    pulse(1);
    probe("sel_on_32", 0, 5, 3, 1, 8'hFC, 0);
    pulse(7);
    probe("cross_sel_on", 0, 13, 9, 1, 8'hFF, 0);
    probe("sel_on_40", 0, 5, 3, 1, 8'hFC, 0);
    sel = 1'b0;
    probe("desel_wait_sof", 0, 5, 3, 1, 8'hFC, 0);
    pulse(1);
    probe("desel_idle", 0, 5, 3, 1, 8'h71, 0);
    press(1'b0);
    check("busy_next", 0, 0, 8'h00, 1);
    probe("press_row11", 0, 13, 11, 1, 8'hFF, 1);
    probe("press_row0", 0, 13, 0, 1, 8'h00, 1);
    probe("press_row1", 0, 13, 1, 1, 8'h00, 1);
    probe("press_hbar_low", 0, 9, 20, 1, 8'hFF, 1);
    probe("press_hbar_gone", 0, 9, 14, 1, 8'h71, 1);
    pulse(7);
    check("busy_7", 0, 0, 8'h00, 1);
    pulse(1);
    check("busy_8", 0, 0, 8'h00, 0);
    probe("after_press_idle", 0, 5, 3, 1, 8'h71, 0);
    sel = 1'b1;
    press(1'b0);
    pulse(5);
    press(1'b1);
    pulse(7);
    check("restart_busy_7", 0, 0, 8'h00, 1);
    pulse(1);
    check("restart_busy_8", 0, 0, 8'h00, 0);
    probe("after_press_sel", 0, 5, 3, 1, 8'hFC, 0);
    sel = 1'b0;
    pulse(1);
    gs = 2'd1;
    probe("glyph_hold", 0, 13, 9, 1, 8'hFF, 0);
    pulse(1);
    probe("minus_face", 0, 13, 9, 1, 8'h71, 0);
    probe("minus_bar", 0, 9, 14, 1, 8'hFF, 0);
    gs = 2'd3;
    pulse(1);
    probe("bad_glyph_bar", 1, 26, 28, 1, 8'h00, 0);
    probe("bad_glyph_face", 1, 10, 6, 1, 8'h00, 0);
    probe("blank_glyph", 0, 13, 9, 1, 8'h71, 0);
    gs = 2'd2;
    pulse(1);
    probe("vbar_on", 0, 13, 9, 1, 8'hFF, 0);
    probe("vbar_hbar_off", 0, 9, 14, 1, 8'h71, 0);
    probe("scaled_vbar", 1, 26, 18, 1, 8'hFF, 0);
    press(1'b0);
    pulse(3);
    check("busy_before_rst", 0, 0, 8'h00, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_mid_a", 0, 1, 8'h00, 0);
    check("rst_mid_b", 1, 1, 8'h00, 0);
    probe("rst_glyph0_unshifted", 0, 9, 14, 1, 8'hFF, 0);
    probe("scale_13_9", 1, 26, 18, 1, 8'hFF, 0);
    probe("scale_13_14", 1, 26, 28, 1, 8'hFF, 0);
    probe("scale_face", 1, 10, 6, 1, 8'h71, 0);
    repeat (4) cyc();
    tests++;
    if (qn.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, expected 0", qn.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
